mips_mc_control: RTL and testbench

MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

---
 rtl/mips_mc_control.sv | 198 +++++++++++++++++++
 tb/tb_mips_mc_control.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// -----------------------------------------------------------------------------
// mips_mc_control
//   Main control unit for a multicycle MIPS datapath. A twelve-state Moore
//   FSM steps each instruction through fetch, decode and its execute/memory/
//   writeback phases. The datapath selects and enables are decoded from the
//   registered state. PCEn also folds in the ALU zero flag for beq, and the
//   ALU operation in EXEC follows the R-type function field.
//
// Ports
//   clk         system clock, rising-edge active
//   reset       synchronous, active-low reset
//   Op          opcode field Instr[31:26]
//   Funct       function field Instr[5:0]
//   zero        ALU zero flag
//   IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA
//               single-bit datapath selects and enables
//   ALUSrcB     ALU B select (00 B, 01 const 4, 10 SignImm, 11 SignImm<<2)
//   PCSrc       next-PC select (00 ALUResult, 01 ALUOut, 10 jump target)
//   ALUControl  ALU operation (010 add, 110 sub, 000 and, 001 or, 111 slt)
//   PCEn        PC load enable
//   p_state     current state encoding, exported for debug
// -----------------------------------------------------------------------------
module mips_mc_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic       PCEn,
    output logic [3:0] p_state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state;
    logic   pc_write;
    logic   branch;

    // R-type function field to ALU operation; unknown functions fall back to add.
    function automatic logic [2:0] alu_from_funct(input logic [5:0] funct);
        case (funct)
            6'b100000: return ALU_ADD;
            6'b100010: return ALU_SUB;
            6'b100100: return ALU_AND;
            6'b100101: return ALU_OR;
            6'b101010: return ALU_SLT;
            default:   return ALU_ADD;
        endcase
    endfunction

    // Op and Funct are only looked at from DECODE and MEMADR here (and from
    // EXEC in the output decode), so instruction-register changes in any
    // other state cannot disturb the sequence.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // values from before the edge; combinational blocks below use blocking (=).
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    case (Op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYPE:     state <= EXEC;
                        OP_BEQ:       state <= BRANCH;
                        OP_ADDI:      state <= ADDIEX;
                        OP_J:         state <= JUMP;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR: state <= (Op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:  state <= MEMWB;
                EXEC:   state <= ALUWB;
                ADDIEX: state <= ADDIWB;
                MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP: state <= FETCH;
                // Encodings 12-15 recover to FETCH.
                default: state <= FETCH;
            endcase
        end
    end

    assign p_state = state;

    always_comb begin
        // NOTE: every output gets a default before the case so no path through
        // this block leaves a signal unassigned, which would infer a latch.
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ALUControl = ALU_ADD;
        pc_write   = 1'b0;
        branch     = 1'b0;

        case (state)
            FETCH: begin
                IRWrite  = 1'b1;
                pc_write = 1'b1;
                ALUSrcB  = 2'b01;
            end
            DECODE: begin
                // Precompute the branch target while the register file reads.
                ALUSrcB = 2'b11;
            end
            MEMADR, ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                IorD = 1'b1;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            EXEC: begin
                ALUSrcA    = 1'b1;
                ALUControl = alu_from_funct(Funct);
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                branch     = 1'b1;
            end
            ADDIWB: begin
                RegWrite = 1'b1;
            end
            JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase

        PCEn = pc_write | (branch & zero);

        // Hold every state-changing enable low while reset is applied, so a
        // reset landing mid-instruction cannot complete a write.
        if (!reset) begin
            IRWrite  = 1'b0;
            PCEn     = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// -----------------------------------------------------------------------------
// tb_mips_mc_control
//   Self-checking bench for mips_mc_control. Each instruction class maps to
//   its expected p_state sequence; a reference function gives the expected
//   control word for a state number. Op/Funct carry random garbage in states
//   that must ignore them, and zero is driven per instruction or at random.
// -----------------------------------------------------------------------------
module tb_mips_mc_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       zero;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic       PCEn;
    logic [3:0] p_state;

    int checks = 0;
    int errors = 0;

    mips_mc_control dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .zero       (zero),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUControl (ALUControl),
        .PCEn       (PCEn),
        .p_state    (p_state)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       memto_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_control;
        logic       pc_en;
    } ctl_t;

    // Expected control word for a state number, written from the per-state
    // output table; unlisted outputs are 0 and the ALU defaults to add.
    function automatic ctl_t model_out(input int st, input logic [5:0] funct,
                                       input logic z, input logic rst_n);
        ctl_t c;
        c = '0;
        c.alu_control = 3'b010;
        case (st)
            0:  begin c.ir_write = 1; c.pc_en = 1; c.alu_src_b = 2'b01; end
            1:  c.alu_src_b = 2'b11;
            2, 9: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            3:  c.iord = 1;
            4:  begin c.memto_reg = 1; c.reg_write = 1; end
            5:  begin c.iord = 1; c.mem_write = 1; end
            6:  begin
                c.alu_src_a = 1;
                case (funct)
                    6'b100010: c.alu_control = 3'b110;
                    6'b100100: c.alu_control = 3'b000;
                    6'b100101: c.alu_control = 3'b001;
                    6'b101010: c.alu_control = 3'b111;
                    default:   c.alu_control = 3'b010;
                endcase
            end
            7:  begin c.reg_dst = 1; c.reg_write = 1; end
            8:  begin
                c.alu_src_a = 1; c.alu_control = 3'b110;
                c.pc_src = 2'b01; c.pc_en = z;
            end
            10: c.reg_write = 1;
            11: begin c.pc_src = 2'b10; c.pc_en = 1; end
            default: ;
        endcase
        if (!rst_n) begin
            c.ir_write = 0; c.pc_en = 0; c.reg_write = 0; c.mem_write = 0;
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_state(input string tag, input int st, input ctl_t exp);
        ctl_t obs;
        obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, PCSrc, ALUControl, PCEn};
        check($sformatf("%s p_state", tag), {28'd0, p_state}, st);
        check($sformatf("%s ctl@%0d", tag, st), {17'd0, obs}, {17'd0, exp});
    endtask

    // Expected state walk for one instruction, starting at its FETCH.
    function automatic int seq_len(input logic [5:0] op);
        case (op)
            OP_LW:                      return 5;
            OP_SW, OP_RTYPE, OP_ADDI:   return 4;
            OP_BEQ, OP_J:               return 3;
            default:                    return 2;
        endcase
    endfunction

    function automatic int seq_at(input logic [5:0] op, input int idx);
        int s [$];
        case (op)
            OP_LW:    s = {0, 1, 2, 3, 4};
            OP_SW:    s = {0, 1, 2, 5};
            OP_RTYPE: s = {0, 1, 6, 7};
            OP_ADDI:  s = {0, 1, 9, 10};
            OP_BEQ:   s = {0, 1, 8};
            OP_J:     s = {0, 1, 11};
            default:  s = {0, 1};
        endcase
        return s[idx];
    endfunction

    // Drive one instruction. zero_mode: 0/1 fixed, 2 random per cycle.
    // abort_idx >= 0 applies reset at that step and stops the instruction.
    task automatic run_instr(input string tag, input logic [5:0] op,
                             input logic [5:0] funct, input int zero_mode,
                             input int abort_idx);
        int   n;
        int   st;
        ctl_t exp;
        n = seq_len(op);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            st = seq_at(op, i);
            // Only DECODE, MEMADR and EXEC may look at the instruction fields.
            if (st == 1 || st == 2 || st == 6) begin
                Op = op;
                Funct = funct;
            end else begin
                Op = 6'($urandom);
                Funct = 6'($urandom);
            end
            zero  = (zero_mode == 2) ? 1'($urandom) : 1'(zero_mode);
            reset = (i == abort_idx) ? 1'b0 : 1'b1;
            #1;
            exp = model_out(st, Funct, zero, reset);
            check_state(tag, st, exp);
            if (i == abort_idx) begin
                // Reset taken on this edge: next cycle is FETCH with the
                // enables still held low.
                @(negedge clk);
                Op = 6'($urandom);
                zero = 1'($urandom);
                #1;
                check_state({tag, " abort"}, 0, model_out(0, Funct, zero, 1'b0));
                break;
            end
        end
    endtask

    initial begin
        logic [5:0] op_tbl [8];
        logic [5:0] fn_tbl [6];
        logic [5:0] op;
        logic [5:0] fn;
        int         ab;

        op_tbl = '{OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_J, 6'b111111, 6'b000001};
        fn_tbl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

        // Reset state: held low for two edges, enables forced low.
        reset = 1'b0;
        Op    = 6'($urandom);
        Funct = 6'($urandom);
        zero  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_state("reset", 0, model_out(0, Funct, zero, 1'b0));
        @(negedge clk);
        check_state("reset2", 0, model_out(0, Funct, zero, 1'b0));

        // Directed instruction walks; the first FETCH after reset must raise
        // IRWrite and PCEn.
        run_instr("lw",        OP_LW,       6'b000000, 0, -1);
        run_instr("sub",       OP_RTYPE,    6'b100010, 0, -1);
        run_instr("beq_z1",    OP_BEQ,      6'b000000, 1, -1);
        run_instr("beq_z0",    OP_BEQ,      6'b000000, 0, -1);
        run_instr("bad_op",    6'b111111,   6'b100010, 1, -1);
        run_instr("sw_abort",  OP_SW,       6'b000000, 0,  2);
        run_instr("j",         OP_J,        6'b000000, 0, -1);
        run_instr("addi",      OP_ADDI,     6'b000000, 2, -1);
        run_instr("sw",        OP_SW,       6'b000000, 2, -1);
        run_instr("add",       OP_RTYPE,    6'b100000, 0, -1);
        run_instr("and",       OP_RTYPE,    6'b100100, 0, -1);
        run_instr("or",        OP_RTYPE,    6'b100101, 0, -1);
        run_instr("slt",       OP_RTYPE,    6'b101010, 0, -1);
        run_instr("rt_unk",    OP_RTYPE,    6'b111000, 0, -1);
        run_instr("alu_abort", OP_RTYPE,    6'b101010, 0,  3);
        run_instr("lw_abort",  OP_LW,       6'b000000, 0,  4);
        run_instr("addi_abt",  OP_ADDI,     6'b000000, 0,  3);

        // Randomized instruction stream with occasional mid-instruction resets.
        for (int k = 0; k < 60; k++) begin
            op = op_tbl[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            fn = fn_tbl[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
            ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, seq_len(op) - 1) : -1;
            run_instr($sformatf("rand%0d", k), op, fn, 2, ab);
        end

        // Stream ends back at FETCH.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_state("final", 0, model_out(0, Funct, zero, 1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
